// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// State encoding and RAM width defaults.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_MEM_WIDTH  = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_RESP  = ST_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Searches upward from last+1 with wrap; returns one-hot and index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sel   = 0;
    for (int k = 1; k <= N; k++) begin
      sel = (int'(last) + k) % N;
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        idx        = IW'(sel);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among requesters.
// Each access runs IDLE -> ISSUE -> RESP through the registered read path.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int REQ_COUNT  = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [REQ_COUNT-1:0]            req_valid,
  input  logic [REQ_COUNT-1:0]            req_write,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_COUNT*MEM_WIDTH-1:0]  req_wdata,
  output logic [REQ_COUNT-1:0]            req_ready,
  output logic [REQ_COUNT-1:0]            rsp_valid,
  output logic [MEM_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [MEM_WIDTH-1:0]            mem_datain,
  output logic                            mem_write,
  input  logic [MEM_WIDTH-1:0]            mem_dataout,
  output logic                            busy
);

  localparam int IW = $clog2(REQ_COUNT);

  arb_state_t           state;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        owner;
  logic [REQ_COUNT-1:0] pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 mem_write_q;
  logic [MEM_WIDTH-1:0] rdata_q;
  logic                 idle_ok;
  logic                 accept;

  rr_pick #(
    .N  (REQ_COUNT),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign idle_ok   = (state == S_IDLE) && reset;
  assign req_ready = idle_ok ? pick_grant : '0;
  assign accept    = idle_ok && pick_any;
  assign busy      = (state != S_IDLE);

  // Gated so a write caught by reset in ISSUE never reaches the RAM.
  assign mem_write = mem_write_q & reset;

  assign rsp_rdata = (|rsp_valid) ? mem_dataout : rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      last_grant  <= IW'(REQ_COUNT - 1);
      owner       <= '0;
      mem_address <= '0;
      mem_datain  <= '0;
      mem_write_q <= 1'b0;
      rsp_valid   <= '0;
      rdata_q     <= '0;
    end else begin
      mem_write_q <= 1'b0;
      rsp_valid   <= '0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_ISSUE;
            owner       <= pick_idx;
            last_grant  <= pick_idx;
            mem_address <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_datain  <= req_wdata[pick_idx*MEM_WIDTH +: MEM_WIDTH];
            mem_write_q <= req_write[pick_idx];
          end
        end
        S_ISSUE: begin
          state     <= S_RESP;
          rsp_valid <= REQ_COUNT'(1) << owner;
        end
        S_RESP: begin
          state   <= S_IDLE;
          rdata_q <= mem_dataout;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// Includes a write-first registered RAM and a round-robin reference model.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_datain, mem_dataout;
  logic [AW-1:0]   mem_address;
  logic            mem_write, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .REQ_COUNT  (N),
    .ADDR_WIDTH (AW),
    .MEM_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_address (mem_address),
    .mem_datain  (mem_datain),
    .mem_write   (mem_write),
    .mem_dataout (mem_dataout),
    .busy        (busy)
  );

  function automatic logic [DW-1:0] init_val(int a);
    if (a == 16) return 12'hABC;
    return DW'((a * 37 + 5) ^ 32'h5A);
  endfunction

  // Environment RAM: registered read, write-first.
  logic [DW-1:0] ram [0:4095];
  logic          ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int a = 0; a < 4096; a++) ram[a] <= init_val(a);
      ram_ready   <= 1'b1;
      mem_dataout <= '0;
    end else if (mem_write) begin
      ram[mem_address] <= mem_datain;
      mem_dataout      <= mem_datain;
    end else begin
      mem_dataout <= ram[mem_address];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            owner;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb [$];
  rsp_t          r;
  txn_t          cur;
  logic [DW-1:0] shadow [0:4095];
  logic [DW-1:0] hold;
  logic [N-1:0]  exp_ready;
  logic [N-1:0]  acc_vec = '0;
  bit            armed = 1'b0;
  int            stage, last, w;

  function automatic int rr_model(logic [N-1:0] v, int lg);
    for (int k = 1; k <= N; k++)
      if (v[(lg + k) % N]) return (lg + k) % N;
    return -1;
  endfunction

  // stage counts cycles since an accept: 1 = address cycle, 2 = response.
  always @(negedge clk) begin
    cyc++;
    if (!armed) begin
      if (!reset) begin
        armed = 1'b1;
        stage = 0;
        last  = N - 1;
        hold  = '0;
        sb.delete();
        for (int a = 0; a < 4096; a++) shadow[a] = init_val(a);
      end
      acc_vec = '0;
    end else begin
      w = rr_model(req_valid, last);
      exp_ready = '0;
      if (stage == 0 && reset && w >= 0) exp_ready[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(stage != 0));
      chk("mem_write", 32'(mem_write),
          32'(stage == 1 && cur.wr && reset));
      if (stage == 1) begin
        chk("mem_address", 32'(mem_address), 32'(cur.addr));
        if (cur.wr) chk("mem_datain", 32'(mem_datain), 32'(cur.wdata));
      end
      if (rsp_valid !== '0 || stage == 2) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          r = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1 << r.owner));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
          hold = r.data;
        end
      end else begin
        chk("rsp_hold", 32'(rsp_rdata), 32'(hold));
      end

      acc_vec = req_valid & req_ready;
      if (!reset) begin
        stage = 0;
        last  = N - 1;
        hold  = '0;
        sb.delete();
      end else if (stage == 1) begin
        r.owner = cur.owner;
        r.data  = cur.wr ? cur.wdata : shadow[cur.addr];
        if (cur.wr) shadow[cur.addr] = cur.wdata;
        sb.push_back(r);
        stage = 2;
      end else if (stage == 2) begin
        stage = 0;
      end else if (w >= 0) begin
        cur.owner = w;
        cur.wr    = req_write[w];
        cur.addr  = req_addr[w*AW +: AW];
        cur.wdata = req_wdata[w*DW +: DW];
        last      = w;
        stage     = 1;
      end
    end
  end

  logic          v  [N];
  logic          wr [N];
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];
  int            mode = 0;

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = v[i];
      req_write[i]            = wr[i];
      req_addr[i*AW +: AW]    = ad[i];
      req_wdata[i*DW +: DW]   = wd[i];
    end
  endtask

  // mode 0: random, 1: all valid, 2: only 1 and 3, 3: idle
  task automatic drive();
    bit want;
    for (int i = 0; i < N; i++) begin
      if (acc_vec[i]) v[i] = 1'b0;
      if (mode == 3 || (mode == 2 && (i == 0 || i == 2))) begin
        v[i] = 1'b0;
      end else if (!v[i]) begin
        want = (mode == 1) ||
               (mode == 2 && $urandom_range(0, 2) == 0) ||
               (mode == 0 && $urandom_range(0, 3) == 0);
        if (want) begin
          v[i]  = 1'b1;
          wr[i] = 1'($urandom_range(0, 1));
          ad[i] = AW'($urandom_range(0, 47));
          wd[i] = DW'($urandom);
        end
      end else if (mode != 1 && $urandom_range(0, 19) == 0) begin
        v[i] = 1'b0;
      end
    end
    pack();
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    pack();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    mode = 1; run(60);
    mode = 2; run(90);
    mode = 0; run(300);
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
        run(1);
        if (mem_write) found = 1'b1;
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL reset_wait: no write issued within 200 cycles");
      end else begin
        reset = 1'b0;
        run(2);
        reset = 1'b1;
        run(20);
      end
    end
    mode = 0; run(200);
    mode = 3; run(10);
    for (int a = 0; a < 64; a++)
      chk("ram_content", 32'(ram[a]), 32'(shadow[a]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
